pc_branch_unit: RTL and testbench

- Parametrised program-counter and branch-resolution block for the RISC-V core.
- Holds the fetch PC and presents it to instruction memory through a valid/ready handshake.
- Resolves conditional branches (all six RV32I compares), JAL and JALR, and produces link address, redirect and flush.
- Replaces the fixed 32-bit PC/branch logic inside the datapath; the ALU no longer evaluates branch conditions.

---
 rtl/pcu_pkg.sv | 35 +++
 rtl/pc_branch_unit_branch_cmp.sv | 36 +++
 rtl/pc_branch_unit.sv | 195 +++++++++++++++++++
 tb/tb_pc_branch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcu_pkg.sv
// Shared encodings for the PC / branch-resolution block: control-transfer
// kinds, branch funct3 codes, fetch FSM states and counter helpers.
package pcu_pkg;

   // Control-transfer kind as presented by decode
   typedef enum logic [1:0] {
      CTL_BRANCH = 2'b00,
      CTL_JAL    = 2'b01,
      CTL_JALR   = 2'b10,
      CTL_RSVD   = 2'b11
   } ctl_kind_e;

   // RV32I conditional-branch funct3 codes (010/011 are unused)
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Fetch sequencing states
   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10
   } pcu_state_e;

   localparam logic [31:0] PERF_CNT_MAX = '1;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == PERF_CNT_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pc_branch_unit_branch_cmp.sv
// branch_cmp: combinational evaluation of the six RV32I branch conditions.
// Unused funct3 codes evaluate to false.
module branch_cmp
   import pcu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            cond_true
);

   logic w_eq;
   logic w_lt;
   logic w_ltu;

   assign w_eq  = (rs1 == rs2);
   assign w_lt  = ($signed(rs1) < $signed(rs2));
   assign w_ltu = (rs1 < rs2);

   // Select the comparison result named by funct3
   always_comb begin
      cond_true = 1'b0;
      case (funct3)
         F3_BEQ:  cond_true = w_eq;
         F3_BNE:  cond_true = ~w_eq;
         F3_BLT:  cond_true = w_lt;
         F3_BGE:  cond_true = ~w_lt;
         F3_BLTU: cond_true = w_ltu;
         F3_BGEU: cond_true = ~w_ltu;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: fetch PC register with valid/ready fetch handshake,
// resolution of conditional branches, JAL and JALR, link address generation
// and one-cycle redirect/flush pulses.
// Optional build macro PC_PERF_CNT_EN adds saturating branch/taken counters.
module pc_branch_unit
   import pcu_pkg::*;
#(
   parameter int unsigned       XLEN        = 32,
   parameter logic [XLEN-1:0]   RESET_PC    = '0,
   parameter int unsigned       INSTR_BYTES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            if_ready_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_valid_o,
   input  logic            ctl_valid_i,
   input  logic [1:0]      ctl_kind_i,
   input  logic [2:0]      br_funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] instr_pc_i,
   output logic            taken_o,
   output logic            redirect_o,
   output logic            flush_o,
   output logic [XLEN-1:0] link_o,
   output logic            misalign_o
`ifdef PC_PERF_CNT_EN
   ,
   output logic [31:0]     branch_cnt_o,
   output logic [31:0]     taken_cnt_o
`endif
);

   localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);
   localparam logic [XLEN-1:0] LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   pcu_state_e      r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_pc_valid;
   logic            r_taken;
   logic            r_redirect;
   logic            r_flush;
   logic            r_misalign;
   logic [XLEN-1:0] r_link;

   ctl_kind_e       w_kind;
   logic            w_cond_true;
   logic            w_taken_any;
   logic            w_is_jump;
   logic            w_aligned;
   logic            w_redirect;
   logic            w_misalign;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_seq_pc;
   logic [XLEN-1:0] w_link_val;

   assign w_kind     = ctl_kind_e'(ctl_kind_i);
   assign w_jalr_sum = rs1_i + imm_i;
   assign w_seq_pc   = r_pc + STEP;
   assign w_link_val = instr_pc_i + STEP;

   branch_cmp #(
      .XLEN (XLEN)
   ) u_cmp (
      .funct3    (br_funct3_i),
      .rs1       (rs1_i),
      .rs2       (rs2_i),
      .cond_true (w_cond_true)
   );

   // Decide whether a transfer is taken and compute its target
   always_comb begin
      w_taken_any = 1'b0;
      w_is_jump   = 1'b0;
      w_target    = instr_pc_i + imm_i;
      if (ctl_valid_i) begin
         case (w_kind)
            CTL_BRANCH: w_taken_any = w_cond_true;
            CTL_JAL: begin
               w_taken_any = 1'b1;
               w_is_jump   = 1'b1;
            end
            CTL_JALR: begin
               w_taken_any = 1'b1;
               w_is_jump   = 1'b1;
               w_target    = w_jalr_sum & LSB_MASK;
            end
            default: w_taken_any = 1'b0;
         endcase
      end
   end

   // A misaligned target is reported instead of followed; taken_o only
   // pulses for transfers that actually redirect fetch.
   assign w_aligned  = (w_target[1:0] == 2'b00);
   assign w_redirect = w_taken_any & w_aligned;
   assign w_misalign = w_taken_any & ~w_aligned;

   // Fetch FSM, PC register and one-cycle status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_BOOT;
         r_pc       <= RESET_PC;
         r_pc_valid <= 1'b0;
         r_taken    <= 1'b0;
         r_redirect <= 1'b0;
         r_flush    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_taken    <= w_redirect;
         r_redirect <= w_redirect;
         r_flush    <= w_redirect;
         r_misalign <= w_misalign;
         if (w_redirect) begin
            // Redirect wins over stall/ready from any state
            r_pc       <= w_target;
            r_state    <= ST_RUN;
            r_pc_valid <= 1'b1;
         end else begin
            case (r_state)
               ST_BOOT: begin
                  r_state    <= ST_RUN;
                  r_pc_valid <= 1'b1;
               end
               ST_RUN: begin
                  if (stall_i) begin
                     r_state    <= ST_HOLD;
                     r_pc_valid <= 1'b0;
                  end else begin
                     r_pc_valid <= 1'b1;
                     if (r_pc_valid && if_ready_i) begin
                        r_pc <= w_seq_pc;
                     end
                  end
               end
               ST_HOLD: begin
                  if (!stall_i) begin
                     r_state    <= ST_RUN;
                     r_pc_valid <= 1'b1;
                  end
               end
               default: begin
                  r_state    <= ST_BOOT;
                  r_pc_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   // Link address captured on every JAL/JALR, held otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         r_link <= '0;
      end else if (w_is_jump) begin
         r_link <= w_link_val;
      end
   end

`ifdef PC_PERF_CNT_EN
   logic [31:0] r_branch_cnt;
   logic [31:0] r_taken_cnt;

   // Saturating counts of branches seen and transfers that redirected
   always_ff @(posedge clk) begin
      if (rst) begin
         r_branch_cnt <= '0;
         r_taken_cnt  <= '0;
      end else begin
         if (ctl_valid_i && (w_kind == CTL_BRANCH)) begin
            r_branch_cnt <= sat_inc(r_branch_cnt);
         end
         if (w_redirect) begin
            r_taken_cnt <= sat_inc(r_taken_cnt);
         end
      end
   end

   assign branch_cnt_o = r_branch_cnt;
   assign taken_cnt_o  = r_taken_cnt;
`endif

   assign pc_o       = r_pc;
   assign pc_valid_o = r_pc_valid;
   assign taken_o    = r_taken;
   assign redirect_o = r_redirect;
   assign flush_o    = r_flush;
   assign link_o     = r_link;
   assign misalign_o = r_misalign;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Testbench for pc_branch_unit: directed control-transfer vectors with
// hand-computed expectations plus a cycle-level reference model.
module tb_pc_branch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        if_ready_i;
   logic [31:0] pc_o;
   logic        pc_valid_o;
   logic        ctl_valid_i;
   logic [1:0]  ctl_kind_i;
   logic [2:0]  br_funct3_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic [31:0] imm_i;
   logic [31:0] instr_pc_i;
   logic        taken_o;
   logic        redirect_o;
   logic        flush_o;
   logic [31:0] link_o;
   logic        misalign_o;
`ifdef PC_PERF_CNT_EN
   logic [31:0] branch_cnt_o;
   logic [31:0] taken_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   pc_branch_unit #(
      .XLEN        (32),
      .RESET_PC    (RST_PC),
      .INSTR_BYTES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .if_ready_i  (if_ready_i),
      .pc_o        (pc_o),
      .pc_valid_o  (pc_valid_o),
      .ctl_valid_i (ctl_valid_i),
      .ctl_kind_i  (ctl_kind_i),
      .br_funct3_i (br_funct3_i),
      .rs1_i       (rs1_i),
      .rs2_i       (rs2_i),
      .imm_i       (imm_i),
      .instr_pc_i  (instr_pc_i),
      .taken_o     (taken_o),
      .redirect_o  (redirect_o),
      .flush_o     (flush_o),
      .link_o      (link_o),
      .misalign_o  (misalign_o)
`ifdef PC_PERF_CNT_EN
      ,
      .branch_cnt_o(branch_cnt_o),
      .taken_cnt_o (taken_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic        m_init = 1'b0;
   logic        m_boot;
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_taken, m_redir, m_flush, m_mis;
   logic [31:0] m_link;
`ifdef PC_PERF_CNT_EN
   logic [31:0] m_bcnt, m_tcnt;
`endif

   // What the instruction in flight asks for, straight from the ISA rules
   function automatic void resolve(output logic tk, output logic [31:0] tgt);
      logic [31:0] s;
      tk  = 1'b0;
      tgt = instr_pc_i + imm_i;
      if (ctl_valid_i) begin
         if (ctl_kind_i == 2'd1) tk = 1'b1;
         else if (ctl_kind_i == 2'd2) begin
            tk  = 1'b1;
            s   = rs1_i + imm_i;
            tgt = {s[31:1], 1'b0};
         end else if (ctl_kind_i == 2'd0) begin
            case (br_funct3_i)
               3'd0: tk = (rs1_i == rs2_i);
               3'd1: tk = (rs1_i != rs2_i);
               3'd4: tk = ($signed(rs1_i) <  $signed(rs2_i));
               3'd5: tk = ($signed(rs1_i) >= $signed(rs2_i));
               3'd6: tk = (rs1_i <  rs2_i);
               3'd7: tk = (rs1_i >= rs2_i);
               default: tk = 1'b0;
            endcase
         end
      end
   endfunction

   always @(posedge clk) begin
      logic        tk;
      logic [31:0] tgt;
      logic        go;
      resolve(tk, tgt);
      go = tk && (tgt[1:0] == 2'b00);
      if (rst) begin
         m_init  <= 1'b1;
         m_boot  <= 1'b1;
         m_pc    <= RST_PC;
         m_valid <= 1'b0;
         m_taken <= 1'b0; m_redir <= 1'b0; m_flush <= 1'b0; m_mis <= 1'b0;
         m_link  <= 32'd0;
`ifdef PC_PERF_CNT_EN
         m_bcnt  <= 32'd0;
         m_tcnt  <= 32'd0;
`endif
      end else begin
         m_taken <= go; m_redir <= go; m_flush <= go;
         m_mis   <= tk && !go;
         m_pc    <= go ? tgt : ((m_valid && if_ready_i && !stall_i) ? m_pc + 32'd4 : m_pc);
         m_valid <= go || m_boot || !stall_i;
         m_boot  <= 1'b0;
         if (ctl_valid_i && (ctl_kind_i == 2'd1 || ctl_kind_i == 2'd2))
            m_link <= instr_pc_i + 32'd4;
`ifdef PC_PERF_CNT_EN
         if (ctl_valid_i && ctl_kind_i == 2'd0 && m_bcnt != 32'hFFFF_FFFF) m_bcnt <= m_bcnt + 1;
         if (go && m_tcnt != 32'hFFFF_FFFF) m_tcnt <= m_tcnt + 1;
`endif
      end
   end

   // Compare every output against the model on the falling edge
   always @(negedge clk) begin
      if (m_init) begin
         check("mdl_pc",       pc_o,       m_pc);
         check("mdl_valid",    pc_valid_o, m_valid);
         check("mdl_taken",    taken_o,    m_taken);
         check("mdl_redirect", redirect_o, m_redir);
         check("mdl_flush",    flush_o,    m_flush);
         check("mdl_misalign", misalign_o, m_mis);
         check("mdl_link",     link_o,     m_link);
`ifdef PC_PERF_CNT_EN
         check("mdl_bcnt",     branch_cnt_o, m_bcnt);
         check("mdl_tcnt",     taken_cnt_o,  m_tcnt);
`endif
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im, input logic [31:0] ipc);
      ctl_valid_i = 1'b1; ctl_kind_i = k; br_funct3_i = f3;
      rs1_i = a; rs2_i = b; imm_i = im; instr_pc_i = ipc;
      cyc();
      ctl_valid_i = 1'b0;
   endtask

   task automatic pulses(input string tag, input logic t, input logic r, input logic f, input logic m);
      check({tag, "_taken"},    taken_o,    t);
      check({tag, "_redirect"}, redirect_o, r);
      check({tag, "_flush"},    flush_o,    f);
      check({tag, "_misalign"}, misalign_o, m);
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; if_ready_i = 1'b1;
      ctl_valid_i = 1'b0; ctl_kind_i = 2'd0; br_funct3_i = 3'd0;
      rs1_i = '0; rs2_i = '0; imm_i = '0; instr_pc_i = '0;
      cyc(); cyc();
      check("rst_pc", pc_o, 32'h100);
      check("rst_valid", pc_valid_o, 1'b0);
      check("rst_link", link_o, 32'h0);
      pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0);

      // boot cycle, then sequential fetch
      rst = 1'b0;
      cyc(); check("boot_pc", pc_o, 32'h100); check("boot_valid", pc_valid_o, 1'b1);
      cyc(); check("seq_pc1", pc_o, 32'h104);
      cyc(); check("seq_pc2", pc_o, 32'h108);
      if_ready_i = 1'b0;
      cyc(); cyc(); check("notready_hold", pc_o, 32'h108);
      if_ready_i = 1'b1;
      cyc(); check("ready_again", pc_o, 32'h10C);

      // BEQ taken / not taken
      ctl(2'd0, 3'd0, 32'd5, 32'd5, 32'hFFFF_FFF8, 32'h200);
      check("beq_pc", pc_o, 32'h1F8); pulses("beq", 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(); check("beq_after_pc", pc_o, 32'h1FC); pulses("beq_after", 1'b0, 1'b0, 1'b0, 1'b0);
      ctl(2'd0, 3'd0, 32'd5, 32'd6, 32'hFFFF_FFF8, 32'h200);
      check("beq_nt_pc", pc_o, 32'h200); pulses("beq_nt", 1'b0, 1'b0, 1'b0, 1'b0);

      // signed vs unsigned compares
      ctl(2'd0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h300);
      check("blt_pc", pc_o, 32'h310); check("blt_taken", taken_o, 1'b1);
      ctl(2'd0, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h300);
      check("bltu_pc", pc_o, 32'h314); check("bltu_taken", taken_o, 1'b0);
      ctl(2'd0, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h300);
      check("bge_pc", pc_o, 32'h318); check("bge_taken", taken_o, 1'b0);
      ctl(2'd0, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h300);
      check("bgeu_pc", pc_o, 32'h310); check("bgeu_taken", taken_o, 1'b1);
      ctl(2'd0, 3'd2, 32'd5, 32'd5, 32'h10, 32'h300);
      check("f3_010_pc", pc_o, 32'h314); check("f3_010_redirect", redirect_o, 1'b0);
      ctl(2'd3, 3'd0, 32'd5, 32'd5, 32'h10, 32'h300);
      check("kind11_pc", pc_o, 32'h318); check("kind11_redirect", redirect_o, 1'b0);

      // JALR clears bit 0; JAL to a misaligned target does not redirect
      ctl(2'd2, 3'd0, 32'h1001, 32'd0, 32'h4, 32'h40);
      check("jalr_pc", pc_o, 32'h1004); check("jalr_link", link_o, 32'h44);
      pulses("jalr", 1'b1, 1'b1, 1'b1, 1'b0);
      ctl(2'd1, 3'd0, 32'd0, 32'd0, 32'h6, 32'h80);
      check("jal_mis_pc", pc_o, 32'h1008); check("jal_mis_link", link_o, 32'h84);
      pulses("jal_mis", 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(); check("mis_after_pc", pc_o, 32'h100C); check("mis_after", misalign_o, 1'b0);

      // stall into HOLD, redirect out of it
      stall_i = 1'b1;
      cyc(); cyc();
      check("hold_pc", pc_o, 32'h100C); check("hold_valid", pc_valid_o, 1'b0);
      ctl(2'd0, 3'd1, 32'd1, 32'd2, 32'h20, 32'h500);
      check("hold_bne_pc", pc_o, 32'h520); check("hold_bne_valid", pc_valid_o, 1'b1);
      check("hold_bne_redirect", redirect_o, 1'b1);
      cyc(); check("restall_valid", pc_valid_o, 1'b0); check("restall_pc", pc_o, 32'h520);
      stall_i = 1'b0;
      cyc(); check("unstall_valid", pc_valid_o, 1'b1); check("unstall_pc", pc_o, 32'h520);
      cyc(); check("unstall_seq", pc_o, 32'h524);

      // target wrap-around and misaligned JALR
      ctl(2'd1, 3'd0, 32'd0, 32'd0, 32'h20, 32'hFFFF_FFF0);
      check("wrap_pc", pc_o, 32'h10); check("wrap_link", link_o, 32'hFFFF_FFF4);
      ctl(2'd2, 3'd0, 32'h2002, 32'd0, 32'd0, 32'h10);
      check("jalr_mis_pc", pc_o, 32'h14); check("jalr_mis_link", link_o, 32'h14);
      pulses("jalr_mis", 1'b0, 1'b0, 1'b0, 1'b1);

      // reset in the same cycle as a taken branch
      rst = 1'b1;
      ctl(2'd0, 3'd0, 32'd5, 32'd5, 32'h40, 32'h600);
      check("rst_br_pc", pc_o, 32'h100); check("rst_br_valid", pc_valid_o, 1'b0);
      pulses("rst_br", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(); check("reboot_pc", pc_o, 32'h100); check("reboot_valid", pc_valid_o, 1'b1);
      cyc(); check("reboot_seq", pc_o, 32'h104);

`ifdef PC_PERF_CNT_EN
      // three branches, two of them taken
      ctl(2'd0, 3'd0, 32'd1, 32'd1, 32'h40, 32'h700);
      ctl(2'd0, 3'd0, 32'd1, 32'd2, 32'h40, 32'h700);
      ctl(2'd0, 3'd1, 32'd1, 32'd2, 32'h40, 32'h700);
      cyc();
      check("perf_branch", branch_cnt_o, 32'd3);
      check("perf_taken",  taken_cnt_o,  32'd2);
`endif

      cyc(); cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
